// File: rtl/inst_sram_responder_pkg.sv
// Shared definitions for the instruction-SRAM responder.
// Holds the default memory placement and the read encoding of the byte-enable field.
// Also provides the byte-lane merge used by the array and its read-through path.
package inst_sram_responder_pkg;

  localparam logic [31:0] INST_RAM_BASE  = 32'h1c000000;
  localparam int          INST_RAM_DEPTH = 1024;
  localparam logic [3:0]  WE_READ        = 4'h0;

  // Replace each lane of old_word whose enable bit is set with the same lane of new_word
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/inst_sram_responder_sram_byte_ram.sv
// Unreset word array with a byte-lane front write port and a full-word backdoor port.
// Writes land on the rising edge; next_word shows the post-edge value of word idx.
// When the backdoor targets the same word as a front write, the backdoor wins for the whole word.
module sram_byte_ram
  import inst_sram_responder_pkg::*;
#(
  parameter int DEPTH = INST_RAM_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wr_data,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_idx,
  input  logic [31:0]      init_data,
  output logic [31:0]      next_word
);

  logic [31:0] mem [DEPTH];
  logic [31:0] wr_word;

  // Current word with the enabled lanes replaced by the front write data
  always_comb begin
    wr_word = merge_lanes(mem[idx], wr_data, wr_be);
  end

  // Value word idx will hold after this edge; backdoor has the final say
  always_comb begin
    next_word = mem[idx];
    if (wr_en) next_word = wr_word;
    if (init_en && (init_idx == idx)) next_word = init_data;
  end

  // Array update; the backdoor assignment comes last so it overrides a same-word front write
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wr_word;
    if (init_en) mem[init_idx] <= init_data;
  end

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction-SRAM responder: decodes fetch requests, answers with a registered word.
// Latency 1 cycle; an access is accepted on every edge with en high, no bubbles.
// No backpressure: rdata holds while en is low so a stalled requester sees a stable word.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = INST_RAM_BASE,
  parameter int          DEPTH_WORDS = INST_RAM_DEPTH,
  parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_sram_en,
  input  logic [3:0]       inst_sram_we,
  input  logic [31:0]      inst_sram_addr,
  input  logic [31:0]      inst_sram_wdata,
  output logic [31:0]      inst_sram_rdata,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_idx,
  input  logic [31:0]      init_data,
  output logic             acc_err,
  output logic [31:0]      err_addr,
  output logic [31:0]      rd_cnt,
  output logic [31:0]      wr_cnt
);

  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0]      off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             is_write;
  logic             mem_wr;
  logic [31:0]      next_word;

  // Address decode; an address below the base wraps to a large offset and lands out of range
  always_comb begin
    off      = inst_sram_addr - ADDR_BASE;
    in_range = (off < SPAN_BYTES);
    idx      = off[IDX_W+1:2];
    is_write = (inst_sram_we != WE_READ);
    // Front writes are suppressed while reset is held; the backdoor is not
    mem_wr   = resetn && inst_sram_en && in_range && is_write;
  end

  sram_byte_ram #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk       (clk),
    .wr_en     (mem_wr),
    .wr_be     (inst_sram_we),
    .idx       (idx),
    .wr_data   (inst_sram_wdata),
    .init_en   (init_en),
    .init_idx  (init_idx),
    .init_data (init_data),
    .next_word (next_word)
  );

  // Response register, error reporting and access counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_sram_rdata <= 32'h0;
      acc_err         <= 1'b0;
      err_addr        <= 32'h0;
      rd_cnt          <= 32'h0;
      wr_cnt          <= 32'h0;
    end else begin
      acc_err <= 1'b0;
      if (inst_sram_en) begin
        if (in_range) begin
          inst_sram_rdata <= next_word;
          if (is_write) wr_cnt <= wr_cnt + 32'd1;
          else          rd_cnt <= rd_cnt + 32'd1;
        end else begin
          inst_sram_rdata <= 32'h0;
          acc_err         <= 1'b1;
          err_addr        <= inst_sram_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench for inst_sram_responder with a word-array reference model.
// The model is compared against every output each cycle; directed steps pin literal values.
// Inputs change on the falling edge, outputs are sampled 1ns after the rising edge.
module tb_inst_sram_responder;

  localparam logic [31:0] BASE  = 32'h1c000000;
  localparam int          DEPTH = 1024;
  localparam int          IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          en = 1'b0;
  logic [3:0]    we = 4'h0;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic [31:0]   rdata;
  logic          init_en = 1'b0;
  logic [IW-1:0] init_idx = '0;
  logic [31:0]   init_data = 32'h0;
  logic          acc_err;
  logic [31:0]   err_addr, rd_cnt, wr_cnt;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  inst_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (en),
    .inst_sram_we    (we),
    .inst_sram_addr  (addr),
    .inst_sram_wdata (wdata),
    .inst_sram_rdata (rdata),
    .init_en         (init_en),
    .init_idx        (init_idx),
    .init_data       (init_data),
    .acc_err         (acc_err),
    .err_addr        (err_addr),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata = 0, m_err_addr = 0, m_rd = 0, m_wr = 0;
  logic        m_err = 0;
  logic [31:0] m_off;
  int          m_i;
  bit          m_hit;

  // An accepted access sees the word as it stands after every update of this edge
  always @(posedge clk) begin
    m_hit = 0;
    if (resetn) begin
      m_err = 0;
      if (en) begin
        m_off = addr - BASE;
        if (m_off < 32'(4 * DEPTH)) begin
          m_i   = int'(m_off / 4);
          m_hit = 1;
          if (we != 4'h0) begin
            for (int l = 0; l < 4; l++)
              if (we[l]) m_mem[m_i][8*l +: 8] = wdata[8*l +: 8];
            m_wr = m_wr + 1;
          end else begin
            m_rd = m_rd + 1;
          end
        end else begin
          m_rdata    = 0;
          m_err      = 1;
          m_err_addr = addr;
        end
      end
    end
    if (init_en) m_mem[init_idx] = init_data;
    if (m_hit) m_rdata = m_mem[m_i];
  end

  always @(negedge resetn) begin
    m_rdata = 0; m_err = 0; m_err_addr = 0; m_rd = 0; m_wr = 0;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (cmp_on) begin
      check32("model_rdata", rdata, m_rdata);
      check32("model_acc_err", {31'b0, acc_err}, {31'b0, m_err});
      check32("model_err_addr", err_addr, m_err_addr);
      check32("model_rd_cnt", rd_cnt, m_rd);
      check32("model_wr_cnt", wr_cnt, m_wr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; we = w; addr = a; wdata = d; init_en = 1'b0;
  endtask

  task automatic drive_init(input int i, input logic [31:0] d);
    init_en = 1'b1; init_idx = IW'(i); init_data = d;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset hold with a request pending; load the image through the backdoor meanwhile
    resetn = 1'b0; en = 1'b1; addr = BASE;
    @(negedge clk);
    cmp_on = 1'b1;
    drive(1, 4'h0, BASE, 0); drive_init(0, 32'h02800c0c); tick();
    drive(1, 4'h0, BASE, 0); drive_init(1, 32'h1c000044); tick();
    drive(1, 4'h0, BASE, 0); tick();
    check32("reset_rdata", rdata, 32'h0);
    check32("reset_rd_cnt", rd_cnt, 32'h0);
    check32("reset_err_addr", err_addr, 32'h0);
    @(negedge clk); en = 1'b0; resetn = 1'b1;

    // 2. Basic back-to-back reads
    drive(1, 4'h0, BASE, 0);     tick(); check32("read0", rdata, 32'h02800c0c);
    drive(1, 4'h0, BASE + 4, 0); tick(); check32("read1", rdata, 32'h1c000044);
    check32("read_rd_cnt", rd_cnt, 32'd2);

    // 3. Hold on stall
    drive(1, 4'h0, BASE + 4, 0); tick();
    drive(0, 4'h0, BASE, 0);
    for (int k = 0; k < 5; k++) begin
      tick(); check32("stall_hold", rdata, 32'h1c000044);
    end

    // 4. Byte-lane write with write-first response, then read back (low address bits ignored)
    drive(0, 4'h0, BASE, 0); drive_init(2, 32'h11223344); tick();
    drive(1, 4'b0101, BASE + 8, 32'haabbccdd); tick();
    check32("bytewr_rdata", rdata, 32'h11bb33dd);
    check32("bytewr_wr_cnt", wr_cnt, 32'd1);
    drive(1, 4'h0, BASE + 32'ha, 0); tick();
    check32("bytewr_readback", rdata, 32'h11bb33dd);

    // 5. Out of range below the base and one past the end
    drive(1, 4'h0, 32'h1bfffffc, 0); tick();
    check32("oor_lo_rdata", rdata, 32'h0);
    check32("oor_lo_err", {31'b0, acc_err}, 32'd1);
    drive(0, 4'h0, BASE, 0); tick();
    check32("oor_err_drops", {31'b0, acc_err}, 32'd0);
    drive(1, 4'hf, BASE + 32'(4 * DEPTH), 32'hffffffff); tick();
    check32("oor_hi_err", {31'b0, acc_err}, 32'd1);
    check32("oor_hi_err_addr", err_addr, 32'h1c001000);
    check32("oor_rd_cnt", rd_cnt, 32'd4);
    check32("oor_wr_cnt", wr_cnt, 32'd1);
    // last word is in range for any low address bits
    drive(0, 4'h0, BASE, 0); drive_init(DEPTH - 1, 32'h55aa0ff0); tick();
    drive(1, 4'h0, BASE + 32'(4 * DEPTH - 1), 0); tick();
    check32("last_word", rdata, 32'h55aa0ff0);
    check32("last_word_err", {31'b0, acc_err}, 32'd0);

    // 6. Backdoor collisions, then reset mid-burst
    drive(1, 4'h0, BASE + 32'hc, 0); drive_init(3, 32'hdeadbeef); tick();
    check32("coll_read", rdata, 32'hdeadbeef);
    drive(1, 4'hf, BASE + 8, 32'h0badf00d); drive_init(2, 32'h12345678); tick();
    check32("coll_write", rdata, 32'h12345678);
    drive(1, 4'h0, BASE + 8, 0); tick();
    check32("coll_write_mem", rdata, 32'h12345678);
    drive(1, 4'h0, BASE, 0);     tick();
    drive(1, 4'h0, BASE + 4, 0); tick();
    @(negedge clk); resetn = 1'b0;
    #1;
    check32("midreset_rdata", rdata, 32'h0);
    check32("midreset_rd_cnt", rd_cnt, 32'h0);
    check32("midreset_wr_cnt", wr_cnt, 32'h0);
    tick();
    @(negedge clk); resetn = 1'b1; en = 1'b0;
    drive(1, 4'h0, BASE + 32'hc, 0); tick();
    check32("post_reset_mem3", rdata, 32'hdeadbeef);
    check32("post_reset_rd_cnt", rd_cnt, 32'd1);

    drive(0, 4'h0, BASE, 0); tick();
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
